// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   MODE_LSL : logical shift left, zero fill at the LSB end
//   MODE_LSR : logical shift right, zero fill at the MSB end
//   MODE_ASR : arithmetic shift right, fill with the operand's sign bit
//   MODE_ROL : rotate left, bits leaving the MSB re-enter at the LSB
package barrel_shifter_pipe_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

endpackage

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One pipeline stage of the barrel shifter.
// Stage K shifts its incoming data by 2^K positions in the carried mode when
// bit K of the carried shift amount is set, otherwise passes it through, and
// registers the result together with valid, mode, shift amount and sign.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   adv               : global advance; stage loads when 1, holds when 0
//   in_*              : contents of the previous stage (or the input port)
//   out_*             : this stage's registered contents
module shift_stage
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_sign,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_sign
);

  localparam int STEP = 1 << K;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_next;

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic [1:0]       mode_reg;
  logic [SHW-1:0]   shamt_reg;
  logic             sign_reg;

  always_comb begin
    shifted = in_data;
    case (in_mode)
      MODE_LSL: shifted = in_data << STEP;
      MODE_LSR: shifted = in_data >> STEP;
      // The sign bit was captured at acceptance; earlier stages may already
      // have shifted the original MSB away, so the carried copy is used.
      MODE_ASR: shifted = (in_data >> STEP) |
                          (in_sign ? ~({WIDTH{1'b1}} >> STEP) : '0);
      MODE_ROL: shifted = (in_data << STEP) | (in_data >> (WIDTH - STEP));
      default:  shifted = in_data;
    endcase
    data_next = in_shamt[K] ? shifted : in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      mode_reg  <= '0;
      shamt_reg <= '0;
      sign_reg  <= 1'b0;
    end else if (adv) begin
      valid_reg <= in_valid;
      data_reg  <= data_next;
      mode_reg  <= in_mode;
      shamt_reg <= in_shamt;
      sign_reg  <= in_sign;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_mode  = mode_reg;
  assign out_shamt = shamt_reg;
  assign out_sign  = sign_reg;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, stage k applying
// a 2^k shift. One result per cycle, latency SHW cycles, valid/ready
// handshake on both sides with a single global advance (the whole pipe
// stalls together; bubbles are not collapsed).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake
//   din, shamt, mode    : operand, shift amount 0..WIDTH-1, 00 LSL 01 LSR 10 ASR 11 ROL
//   out_valid/out_ready : output handshake
//   dout                : result, held stable while stalled
module barrel_shifter_pipe
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  // Element 0 is the input port, element gi+1 is the output of stage gi.
  logic             valid_chain [0:SHW];
  logic [WIDTH-1:0] data_chain  [0:SHW];
  logic [1:0]       mode_chain  [0:SHW];
  logic [SHW-1:0]   shamt_chain [0:SHW];
  logic             sign_chain  [0:SHW];

  logic adv;

  // The last stage can always move when it is empty or being drained.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign valid_chain[0] = in_valid;
  assign data_chain[0]  = din;
  assign mode_chain[0]  = mode;
  assign shamt_chain[0] = shamt;
  assign sign_chain[0]  = din[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi = gi + 1) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .K     (gi)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .in_valid  (valid_chain[gi]),
        .in_data   (data_chain[gi]),
        .in_mode   (mode_chain[gi]),
        .in_shamt  (shamt_chain[gi]),
        .in_sign   (sign_chain[gi]),
        .out_valid (valid_chain[gi+1]),
        .out_data  (data_chain[gi+1]),
        .out_mode  (mode_chain[gi+1]),
        .out_shamt (shamt_chain[gi+1]),
        .out_sign  (sign_chain[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_chain[SHW];
  assign dout      = data_chain[SHW];

  // Control fields of the final stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{mode_chain[SHW], shamt_chain[SHW], sign_chain[SHW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [2:0] shamt;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [0:15];
  vec_t ops  [0:3];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      $display("ok   %s: 0x%0h", name, actual);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    din      = v.din;
    shamt    = v.shamt;
    mode     = v.mode;
  endtask

  initial begin
    int lat;
    int got;
    int idx;
    int last_c;
    logic accept;

    // din, shamt, mode (0 LSL, 1 LSR, 2 ASR, 3 ROL), expected dout
    vecs[0]  = '{8'h96, 3'd3, 2'd0, 8'hB0};
    vecs[1]  = '{8'h96, 3'd3, 2'd1, 8'h12};
    vecs[2]  = '{8'h96, 3'd3, 2'd2, 8'hF2};
    vecs[3]  = '{8'h96, 3'd3, 2'd3, 8'hB4};
    vecs[4]  = '{8'h80, 3'd7, 2'd2, 8'hFF};
    vecs[5]  = '{8'h5A, 3'd0, 2'd0, 8'h5A};
    vecs[6]  = '{8'h5A, 3'd0, 2'd1, 8'h5A};
    vecs[7]  = '{8'hA5, 3'd0, 2'd2, 8'hA5};
    vecs[8]  = '{8'h5A, 3'd0, 2'd3, 8'h5A};
    vecs[9]  = '{8'h01, 3'd7, 2'd0, 8'h80};
    vecs[10] = '{8'h81, 3'd1, 2'd3, 8'h03};
    vecs[11] = '{8'h7F, 3'd2, 2'd2, 8'h1F};
    vecs[12] = '{8'hF0, 3'd4, 2'd1, 8'h0F};
    vecs[13] = '{8'hC3, 3'd5, 2'd3, 8'h78};
    vecs[14] = '{8'h40, 3'd1, 2'd2, 8'h20};
    vecs[15] = '{8'hA5, 3'd1, 2'd0, 8'h4A};

    rst       = 1'b1;
    in_valid  = 1'b0;
    din       = '0;
    shamt     = '0;
    mode      = '0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("reset out_valid", int'(out_valid), 0);
    check("reset dout", int'(dout), 0);
    check("reset in_ready", int'(in_ready), 1);
    rst = 1'b0;
    step();

    // Table: one operand at a time, measure latency and result
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i], 1'b1);
      #1;
      check($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d dout", i), int'(dout), int'(vecs[i].exp));
      step();
    end

    // Streaming: 4 back-to-back operands, out_ready=1
    ops[0] = '{8'h0F, 3'd1, 2'd0, 8'h1E};
    ops[1] = '{8'h0F, 3'd2, 2'd0, 8'h3C};
    ops[2] = '{8'h0F, 3'd3, 2'd0, 8'h78};
    ops[3] = '{8'h0F, 3'd4, 2'd0, 8'hF0};
    got = 0;
    last_c = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(ops[c], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (c < 4) check($sformatf("stream in_ready c%0d", c), int'(in_ready), 1);
      if (out_valid) begin
        if (got < 4) check($sformatf("stream dout %0d", got), int'(dout), int'(ops[got].exp));
        if (got > 0) check($sformatf("stream gap %0d", got), c - last_c, 1);
        last_c = c;
        got++;
      end
      step();
    end
    check("stream count", got, 4);

    // Stall: fill with out_ready=0, hold 5 cycles, then drain
    ops[0] = '{8'h96, 3'd1, 2'd1, 8'h4B};
    ops[1] = '{8'h96, 3'd2, 2'd1, 8'h25};
    ops[2] = '{8'h96, 3'd3, 2'd1, 8'h12};
    ops[3] = '{8'h96, 3'd4, 2'd1, 8'h09};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(ops[idx], 1'b1);
      #1;
      accept = in_valid && in_ready;
      step();
      if (accept) idx++;
    end
    check("stall accepted", idx, 3);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall in_ready c%0d", c), int'(in_ready), 0);
      check($sformatf("stall dout c%0d", c), int'(dout), 8'h4B);
      step();
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) drive(ops[idx], 1'b1);
      else in_valid = 1'b0;
      #1;
      accept = in_valid && in_ready;
      if (out_valid) begin
        if (got < 4) check($sformatf("drain dout %0d", got), int'(dout), int'(ops[got].exp));
        got++;
      end
      step();
      if (accept) idx++;
    end
    check("drain count", got, 4);
    check("drain accepted", idx, 4);

    // Reset with two operands in flight
    drive(vecs[0], 1'b1);
    step();
    drive(vecs[3], 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst in_ready during", int'(in_ready), 1);
    step();
    rst = 1'b0;
    check("rst dout", int'(dout), 0);
    check("rst in_ready after", int'(in_ready), 1);
    for (int c = 0; c < SHW + 2; c++) begin
      check($sformatf("rst out_valid c%0d", c), int'(out_valid), 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
